multi_act_layer: RTL and testbench

// Parametrised successor to the single-lane absolute-value layer.
// - Applies one of four element-wise activations to NUM_CH signed lanes in parallel: pass, abs, relu, leaky-relu.
// - Saturates instead of wrapping, and flags each saturation per lane.
// - Sits between conv/FIR layers in the CNN datapath; it is a helpful producer and a helpful consumer.
// - Uses a 2-entry skid buffer so ready_o is registered and throughput is one word per cycle.

---
 rtl/multi_act_layer.sv | 120 ++++++++++++
 tb/tb_multi_act_layer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_act_layer.sv
// Multi-lane element-wise activation layer (pass/abs/relu/leaky) with per-lane
// saturation flags, behind a 2-entry skid buffer with a registered ready_o.
module multi_act_layer #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_CH     = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        ready_o,
  input  logic                        valid_i,
  input  logic [1:0]                  mode_i,
  input  logic [NUM_CH*WORD_SIZE-1:0] data_r_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [NUM_CH*WORD_SIZE-1:0] data_r_o,
  output logic [NUM_CH-1:0]           sat_o
);

  localparam int DW = NUM_CH * WORD_SIZE;
  localparam logic signed [WORD_SIZE-1:0] MIN_V = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [WORD_SIZE-1:0] MAX_V = {1'b0, {(WORD_SIZE-1){1'b1}}};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_ABS   = 2'd1,
    MODE_RELU  = 2'd2,
    MODE_LEAKY = 2'd3
  } mode_e;

  // One buffer slot; the struct doubles as the observable buffer state.
  typedef struct packed {
    logic              valid;
    logic [NUM_CH-1:0] sat;
    logic [DW-1:0]     data;
  } entry_t;

  // Returns {sat, value} for one lane.
  function automatic logic [WORD_SIZE:0] act_lane(input mode_e mode,
                                                  input logic signed [WORD_SIZE-1:0] x);
    logic                        neg;
    logic                        sat;
    logic signed [WORD_SIZE-1:0] y;
    neg = x[WORD_SIZE-1];
    sat = 1'b0;
    y   = x;
    case (mode)
      MODE_PASS:  y = x;
      MODE_ABS: begin
        if (x == MIN_V) begin
          y   = MAX_V;
          sat = 1'b1;
        end else if (neg) begin
          y = -x;
        end
      end
      MODE_RELU:  if (neg) y = '0;
      MODE_LEAKY: if (neg) y = x >>> LEAK_SHIFT;
      default:    y = x;
    endcase
    return {sat, y};
  endfunction

  logic [DW-1:0]     res_data;
  logic [NUM_CH-1:0] res_sat;

  always_comb begin
    res_data = '0;
    res_sat  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      {res_sat[c], res_data[c*WORD_SIZE +: WORD_SIZE]} =
        act_lane(mode_e'(mode_i), data_r_i[c*WORD_SIZE +: WORD_SIZE]);
    end
  end

  // Handshake: a word moves on any posedge where valid and ready are both high
  // on the same side. The producer must hold valid_i/data_r_i/mode_i stable
  // until ready_o is seen; valid_o/data_r_o/sat_o are held while ready_i is low.
  entry_t m_q;
  entry_t s_q;
  logic   ready_q;
  logic   accept;
  logic   drain;
  logic   load_m;
  logic   load_s;

  assign accept = valid_i & ready_q;
  assign drain  = m_q.valid & ready_i;
  assign load_m = accept & (~m_q.valid | ready_i);
  assign load_s = accept & m_q.valid & ~ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_q.valid <= 1'b0;
      s_q.valid <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (load_m) begin
        m_q <= '{valid: 1'b1, sat: res_sat, data: res_data};
      end else if (drain) begin
        // S can only be full when nothing was accepted, so it refills M here.
        m_q <= s_q;
      end

      if (load_s) begin
        s_q     <= '{valid: 1'b1, sat: res_sat, data: res_data};
        ready_q <= 1'b0;
      end else if (drain) begin
        s_q.valid <= 1'b0;
        ready_q   <= 1'b1;
      end
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = m_q.valid;
  assign data_r_o = m_q.data;
  assign sat_o    = m_q.sat;

endmodule

// File: tb/tb_multi_act_layer.sv
// Bench for multi_act_layer: hand sequences for reset/latency/backpressure,
// a vector table and a random stream, both checked through an expected queue.
module tb_multi_act_layer;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int LS = 3;
  localparam int DW = W * N;
  localparam int EW = DW + N;

  logic          clk      = 1'b0;
  logic          reset_i  = 1'b1;
  logic          valid_i  = 1'b0;
  logic          ready_i  = 1'b0;
  logic [1:0]    mode_i   = 2'd0;
  logic [DW-1:0] data_r_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_r_o;
  logic [N-1:0]  sat_o;

  multi_act_layer #(.WORD_SIZE(W), .NUM_CH(N), .LEAK_SHIFT(LS)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .ready_o  (ready_o),
    .valid_i  (valid_i),
    .mode_i   (mode_i),
    .data_r_i (data_r_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_r_o (data_r_o),
    .sat_o    (sat_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            n_out = 0;
  bit            sb_en = 1'b0;
  bit            rnd_run;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] data;
    logic [N-1:0]  exp_sat;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, EW'(act), EW'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                       input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: integer arithmetic, floor division for leaky.
  function automatic logic [EW-1:0] ref_word(input logic [1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [N-1:0]  s;
    int x, y;
    int maxv;
    maxv = (1 << (W - 1)) - 1;
    r = '0;
    s = '0;
    for (int c = 0; c < N; c++) begin
      x = $signed(d[c*W +: W]);
      y = x;
      case (m)
        2'd1: if (x < 0) begin
          y = -x;
          if (y > maxv) begin
            y = maxv;
            s[c] = 1'b1;
          end
        end
        2'd2: y = (x < 0) ? 0 : x;
        2'd3: y = (x < 0) ? (x - ((1 << LS) - 1)) / (1 << LS) : x;
        default: y = x;
      endcase
      r[c*W +: W] = y[W-1:0];
    end
    return {s, r};
  endfunction

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      4: return 16'h8001;
      default: return W'($urandom);
    endcase
  endfunction

  // driver: call at posedge+1, returns at posedge+1 after the handshake
  task automatic send(input logic [1:0] m, input logic [DW-1:0] d, input logic [EW-1:0] e);
    bit done_h;
    done_h   = 1'b0;
    mode_i   = m;
    data_r_i = d;
    valid_i  = 1'b1;
    for (int k = 0; k < 100 && !done_h; k++) begin
      @(negedge clk);
      if (ready_o) begin
        exp_q.push_back(e);
        done_h = 1'b1;
      end
      tick();
    end
    valid_i = 1'b0;
    if (!done_h) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready_o=0 want ready_o=1 within 100 cycles");
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (sb_en && !reset_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h want no word", {sat_o, data_r_o});
      end else begin
        check("sb_word", {sat_o, data_r_o}, exp_q.pop_front());
        n_out++;
      end
    end
  end

  initial begin
    int base;
    vecs[0] = '{2'd1, pk(16'hFFFB, 16'h0007, 16'h8000, 16'h0000), 4'b0100, pk(16'h0005, 16'h0007, 16'h7FFF, 16'h0000)};
    vecs[1] = '{2'd2, pk(16'hFFF0, 16'hFFFF, 16'h0009, 16'h8000), 4'b0000, pk(16'h0000, 16'h0000, 16'h0009, 16'h0000)};
    vecs[2] = '{2'd3, pk(16'hFFF0, 16'hFFFF, 16'h0009, 16'h8000), 4'b0000, pk(16'hFFFE, 16'hFFFF, 16'h0009, 16'hF000)};
    vecs[3] = '{2'd0, pk(16'hFFF0, 16'hFFFF, 16'h0009, 16'h8000), 4'b0000, pk(16'hFFF0, 16'hFFFF, 16'h0009, 16'h8000)};
    vecs[4] = '{2'd1, pk(16'h7FFF, 16'h8001, 16'h0001, 16'hFFFF), 4'b0000, pk(16'h7FFF, 16'h7FFF, 16'h0001, 16'h0001)};
    vecs[5] = '{2'd1, pk(16'h8000, 16'h8000, 16'h8000, 16'h8000), 4'b1111, pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF)};
    vecs[6] = '{2'd3, pk(16'h0005, 16'hFFF9, 16'hFFF8, 16'hFFF7), 4'b0000, pk(16'h0005, 16'hFFFF, 16'hFFFF, 16'hFFFE)};
    vecs[7] = '{2'd2, pk(16'h7FFF, 16'h0000, 16'h0001, 16'h8001), 4'b0000, pk(16'h7FFF, 16'h0000, 16'h0001, 16'h0000)};

    // reset, then idle
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    mid();
    chk1("reset_valid_o", valid_o, 1'b0);
    chk1("reset_ready_o", ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
      chk1("idle_valid_o", valid_o, 1'b0);
    end

    // abs, one-cycle latency
    tick();
    ready_i  = 1'b1;
    mode_i   = 2'd1;
    data_r_i = vecs[0].data;
    valid_i  = 1'b1;
    mid();
    chk1("abs_ready_o", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    mid();
    chk1("abs_valid_o", valid_o, 1'b1);
    check("abs_word", {sat_o, data_r_o}, {4'b0100, pk(16'h0005, 16'h0007, 16'h7FFF, 16'h0000)});
    tick();
    mid();
    chk1("abs_drained", valid_o, 1'b0);

    // relu then leaky back-to-back
    mode_i   = 2'd2;
    data_r_i = vecs[1].data;
    valid_i  = 1'b1;
    tick();
    mode_i = 2'd3;
    mid();
    chk1("relu_valid_o", valid_o, 1'b1);
    check("relu_word", {sat_o, data_r_o}, {4'b0000, pk(16'h0000, 16'h0000, 16'h0009, 16'h0000)});
    tick();
    valid_i = 1'b0;
    mid();
    chk1("leaky_valid_o", valid_o, 1'b1);
    check("leaky_word", {sat_o, data_r_o}, {4'b0000, pk(16'hFFFE, 16'hFFFF, 16'h0009, 16'hF000)});
    tick();
    mid();
    chk1("leaky_drained", valid_o, 1'b0);

    // backpressure: 1, 2, 3 in pass mode
    tick();
    mode_i   = 2'd0;
    data_r_i = {N{16'd1}};
    valid_i  = 1'b1;
    mid();
    chk1("bp_ready_w1", ready_o, 1'b1);
    tick();
    data_r_i = {N{16'd2}};
    ready_i  = 1'b0;
    mid();
    check("bp_out_w1", EW'(data_r_o), EW'({N{16'd1}}));
    chk1("bp_ready_w2", ready_o, 1'b1);
    tick();
    data_r_i = {N{16'd3}};
    mid();
    chk1("bp_ready_drop", ready_o, 1'b0);
    check("bp_hold_w1a", EW'(data_r_o), EW'({N{16'd1}}));
    tick();
    mid();
    chk1("bp_ready_low", ready_o, 1'b0);
    chk1("bp_valid_hold", valid_o, 1'b1);
    check("bp_hold_w1b", EW'(data_r_o), EW'({N{16'd1}}));
    ready_i = 1'b1;
    tick();
    mid();
    chk1("bp_valid_w2", valid_o, 1'b1);
    check("bp_out_w2", EW'(data_r_o), EW'({N{16'd2}}));
    chk1("bp_ready_back", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    mid();
    chk1("bp_valid_w3", valid_o, 1'b1);
    check("bp_out_w3", EW'(data_r_o), EW'({N{16'd3}}));
    tick();
    mid();
    chk1("bp_drained", valid_o, 1'b0);

    // vector table through the scoreboard
    tick();
    sb_en = 1'b1;
    base  = n_out;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, vecs[i].data, {vecs[i].exp_sat, vecs[i].exp_data});
    end
    repeat (3) tick();
    check("table_count", EW'(n_out - base), EW'(8));
    check("table_queue", EW'(exp_q.size()), EW'(0));

    // random stream with random backpressure
    base    = n_out;
    rnd_run = 1'b1;
    fork
      begin
        logic [1:0]    m;
        logic [DW-1:0] d;
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          m = 2'($urandom_range(0, 3));
          d = pk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
          send(m, d, ref_word(m, d));
        end
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    ready_i = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    tick();
    check("rand_count", EW'(n_out - base), EW'(1000));
    check("rand_queue", EW'(exp_q.size()), EW'(0));
    sb_en = 1'b0;

    // reset while S is full and valid_o is high
    ready_i  = 1'b0;
    mode_i   = 2'd0;
    data_r_i = {N{16'd10}};
    valid_i  = 1'b1;
    tick();
    data_r_i = {N{16'd11}};
    tick();
    valid_i = 1'b0;
    mid();
    chk1("pre_reset_ready_o", ready_o, 1'b0);
    chk1("pre_reset_valid_o", valid_o, 1'b1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    mid();
    chk1("mid_reset_valid_o", valid_o, 1'b0);
    chk1("mid_reset_ready_o", ready_o, 1'b1);
    ready_i = 1'b1;
    tick();
    mode_i   = 2'd1;
    data_r_i = vecs[0].data;
    valid_i  = 1'b1;
    tick();
    valid_i = 1'b0;
    mid();
    chk1("post_reset_valid_o", valid_o, 1'b1);
    check("post_reset_word", {sat_o, data_r_o}, {vecs[0].exp_sat, vecs[0].exp_data});
    tick();
    mid();
    chk1("post_reset_drained", valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
